// File: rtl/vrf_read_arbiter_pkg.sv
// Shared types for the VRF read-port arbiter.
// The optional performance counters are enabled with VRF_ARB_PERF_EN.
package vrf_read_arbiter_pkg;

  localparam int NrReqDef = 4;
  localparam int BeatWDef = 8;
  localparam int RegWDef  = 5;
  localparam int ReqIdW   = $clog2(NrReqDef);

  typedef logic [RegWDef-1:0] vreg_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [ReqIdW-1:0]   id;
    vreg_t               vs;
    logic [BeatWDef-1:0] beats;
  } rd_burst_t;

endpackage

// File: rtl/vrf_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after the pointer.
// The pointer register lives in the parent.
module vrf_read_arbiter_rr_arbiter #(
  parameter int NrReq = 4,
  localparam int IdW = $clog2(NrReq)
) (
  input  logic [NrReq-1:0] i_valid,
  input  logic [IdW-1:0]   i_ptr,
  output logic [NrReq-1:0] o_grant,
  output logic [IdW-1:0]   o_idx,
  output logic             o_any
);

  logic [IdW-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < NrReq; i++) begin
      w_idx = IdW'((int'(i_ptr) + i) % NrReq);
      if (!o_any && i_valid[w_idx]) begin
        o_any          = 1'b1;
        o_idx          = w_idx;
        o_grant[w_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vrf_read_arbiter.sv
// Shares the single VRF read port among operand-queue burst requesters, round-robin.
// Define VRF_ARB_PERF_EN to add the wb/queue stall counters.
//
// state | meaning
// IDLE  | no burst owns the port; arbitrate and accept one request
// BURST | stream beats of the latched burst, one per unstalled cycle
module vrf_read_arbiter
  import vrf_read_arbiter_pkg::*;
#(
  parameter int NrReq = NrReqDef,
  parameter int BeatW = BeatWDef,
  parameter int RegW  = RegWDef,
  localparam int IdW  = $clog2(NrReq)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NrReq-1:0]       req_valid_i,
  output logic [NrReq-1:0]       req_ready_o,
  input  logic [NrReq*RegW-1:0]  req_vs_i,
  input  logic [NrReq*BeatW-1:0] req_beats_i,
  input  logic [NrReq-1:0]       q_ready_i,
  input  logic                   wb_busy_i,
  output logic                   rd_en_o,
  output logic [RegW-1:0]        rd_vs_o,
  output logic [BeatW-1:0]       rd_beat_o,
  output logic [IdW-1:0]         rd_owner_o,
  output logic                   done_o,
  output logic [IdW-1:0]         done_id_o,
  output logic [RegW-1:0]        done_vs_o
`ifdef VRF_ARB_PERF_EN
  ,
  output logic [31:0]            perf_wb_stall_o,
  output logic [31:0]            perf_q_stall_o
`endif
);

  arb_state_e     r_state;
  rd_burst_t      r_burst;
  logic [IdW-1:0] r_rr_ptr;
  logic [BeatW-1:0] r_beat_cnt;
  logic           r_done;
  logic [IdW-1:0] r_done_id;
  logic [RegW-1:0] r_done_vs;

  logic [NrReq-1:0] w_grant;
  logic [IdW-1:0]   w_gidx;
  logic             w_any;
  logic             w_accept;
  logic             w_issue;
  logic             w_last;
  logic [RegW-1:0]  w_gvs;
  logic [BeatW-1:0] w_gbeats;

  function automatic logic [IdW-1:0] next_ptr(input logic [IdW-1:0] id);
    return (id == IdW'(NrReq - 1)) ? '0 : id + 1'b1;
  endfunction

  vrf_read_arbiter_rr_arbiter #(.NrReq(NrReq)) u_rr (
    .i_valid (req_valid_i),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  assign w_gvs    = req_vs_i[w_gidx*RegW +: RegW];
  assign w_gbeats = req_beats_i[w_gidx*BeatW +: BeatW];

  // Ready is gated by reset so every output reads 0 while rst_ni is low.
  assign w_accept    = rst_ni && (r_state == IDLE) && w_any;
  assign req_ready_o = w_accept ? w_grant : '0;

  assign w_issue = (r_state == BURST) && q_ready_i[r_burst.id] && !wb_busy_i;
  assign w_last  = w_issue && (r_beat_cnt == r_burst.beats - BeatW'(1));

  assign rd_en_o    = w_issue;
  assign rd_vs_o    = w_issue ? r_burst.vs : '0;
  assign rd_beat_o  = w_issue ? r_beat_cnt : '0;
  assign rd_owner_o = w_issue ? r_burst.id : '0;

  assign done_o    = r_done;
  assign done_id_o = r_done_id;
  assign done_vs_o = r_done_vs;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_burst    <= '0;
      r_rr_ptr   <= '0;
      r_beat_cnt <= '0;
      r_done     <= 1'b0;
      r_done_id  <= '0;
      r_done_vs  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_burst    <= '{id: w_gidx, vs: w_gvs, beats: w_gbeats};
            r_beat_cnt <= '0;
            if (w_gbeats == '0) begin
              // Empty burst completes without touching the port.
              r_done    <= 1'b1;
              r_done_id <= w_gidx;
              r_done_vs <= w_gvs;
              r_rr_ptr  <= next_ptr(w_gidx);
            end else begin
              r_state <= BURST;
            end
          end
        end
        BURST: begin
          if (w_last) begin
            r_state    <= IDLE;
            r_beat_cnt <= '0;
            r_rr_ptr   <= next_ptr(r_burst.id);
            r_done     <= 1'b1;
            r_done_id  <= r_burst.id;
            r_done_vs  <= r_burst.vs;
          end else if (w_issue) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef VRF_ARB_PERF_EN
  logic [31:0] r_perf_wb;
  logic [31:0] r_perf_q;

  // A cycle blocked by both causes is charged to writeback only.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_perf_wb <= '0;
      r_perf_q  <= '0;
    end else if (r_state == BURST) begin
      if (wb_busy_i) begin
        if (r_perf_wb != '1) r_perf_wb <= r_perf_wb + 32'd1;
      end else if (!q_ready_i[r_burst.id]) begin
        if (r_perf_q != '1) r_perf_q <= r_perf_q + 32'd1;
      end
    end
  end

  assign perf_wb_stall_o = r_perf_wb;
  assign perf_q_stall_o  = r_perf_q;
`endif

endmodule

// File: tb/tb_vrf_read_arbiter.sv
// Directed bench for vrf_read_arbiter with a scoreboard of expected beats, completions and grants.
module tb_vrf_read_arbiter;

  localparam int N  = 4;
  localparam int BW = 8;
  localparam int RW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*RW-1:0] req_vs;
  logic [N*BW-1:0] req_beats;
  logic [N-1:0]    q_ready;
  logic            wb_busy;
  logic            rd_en;
  logic [RW-1:0]   rd_vs;
  logic [BW-1:0]   rd_beat;
  logic [1:0]      rd_owner;
  logic            done;
  logic [1:0]      done_id;
  logic [RW-1:0]   done_vs;
`ifdef VRF_ARB_PERF_EN
  logic [31:0]     perf_wb;
  logic [31:0]     perf_q;
`endif

  vrf_read_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_vs_i    (req_vs),
    .req_beats_i (req_beats),
    .q_ready_i   (q_ready),
    .wb_busy_i   (wb_busy),
    .rd_en_o     (rd_en),
    .rd_vs_o     (rd_vs),
    .rd_beat_o   (rd_beat),
    .rd_owner_o  (rd_owner),
    .done_o      (done),
    .done_id_o   (done_id),
    .done_vs_o   (done_vs)
`ifdef VRF_ARB_PERF_EN
    ,
    .perf_wb_stall_o (perf_wb),
    .perf_q_stall_o  (perf_q)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] sb_rd[$];
  logic [31:0] sb_done[$];
  logic [31:0] sb_grant[$];
  logic [31:0] m_exp;

  int cyc = 0;
  int rd_cnt = 0;
  int first_rd = -1;
  int last_rd = -1;
  int grant_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int g, input logic [RW-1:0] vs, input logic [BW-1:0] beats);
    req_vs[g*RW +: RW]    = vs;
    req_beats[g*BW +: BW] = beats;
  endtask

  task automatic push_beats(input int g, input logic [RW-1:0] vs, input int nbeats);
    logic [1:0] gg;
    gg = 2'(g);
    for (int b = 0; b < nbeats; b++) sb_rd.push_back(32'({gg, vs, 8'(b)}));
  endtask

  task automatic push_done(input int g, input logic [RW-1:0] vs);
    logic [1:0] gg;
    gg = 2'(g);
    sb_done.push_back(32'({gg, vs}));
  endtask

  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((sb_rd.size() != 0 || sb_done.size() != 0) && t < 100) begin
      @(posedge clk);
      t++;
    end
    chk(tag, 32'(sb_rd.size() + sb_done.size()), 32'd0);
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rden"}, 32'(rd_en), 32'd0);
    chk({tag, "_rdvs"}, 32'(rd_vs), 32'd0);
    chk({tag, "_rdbeat"}, 32'(rd_beat), 32'd0);
    chk({tag, "_owner"}, 32'(rd_owner), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_doneid"}, 32'(done_id), 32'd0);
    chk({tag, "_donevs"}, 32'(done_vs), 32'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every issued beat, completion and (queued) grant is checked against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_en) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
        if (sb_rd.size() == 0) chk("rd_extra", 32'(rd_en), 32'd0);
        else begin
          m_exp = sb_rd.pop_front();
          chk("rd_beat", 32'({rd_owner, rd_vs, rd_beat}), m_exp);
        end
      end
      if (done) begin
        if (sb_done.size() == 0) chk("done_extra", 32'(done), 32'd0);
        else begin
          m_exp = sb_done.pop_front();
          chk("done_info", 32'({done_id, done_vs}), m_exp);
        end
      end
      if (|req_ready) begin
        grant_cnt++;
        if (sb_grant.size() != 0) begin
          m_exp = sb_grant.pop_front();
          chk("grant_order", 32'(req_ready), m_exp);
        end
      end
    end
  end

  initial begin
    int t;
    int g0;
    logic [6:0] wb_pat;
    logic [6:0] q_pat;
    logic [6:0] en_pat;
    int order[5];

    req_valid = '0;
    q_ready   = '1;
    wb_busy   = 1'b0;
    req_vs    = '0;
    req_beats = '0;

    // Reset state, with requests pending to show ready is held low.
    rst_n = 1'b0;
    req_valid = 4'b0101;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("rst");
    req_valid = '0;
    rst_n = 1'b1;
    step();

    // Single burst: req0 vs=3 beats=4.
    set_req(0, 5'd3, 8'd4);
    push_beats(0, 5'd3, 4);
    push_done(0, 5'd3);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_ready", 32'(req_ready), 32'h1);
    chk("t1_no_rd_accept", 32'(rd_en), 32'd0);
    step();
    req_valid = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_rden", 32'(rd_en), 32'd1);
      chk("t1_nodone", 32'(done), 32'd0);
    end
    @(negedge clk);
    chk("t1_tail_rden", 32'(rd_en), 32'd0);
    chk("t1_done", 32'(done), 32'd1);
    @(negedge clk);
    chk("t1_done_once", 32'(done), 32'd0);
    drain("t1_drain");

    // Four continuous requesters, 2 beats each, from a fresh pointer.
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst2");
    step();
    rst_n = 1'b1;
    step();
    order = '{0, 1, 2, 3, 0};
    for (int g = 0; g < N; g++) set_req(g, 5'(8 + g), 8'd2);
    for (int k = 0; k < 5; k++) begin
      sb_grant.push_back(32'(1) << order[k]);
      push_beats(order[k], 5'(8 + order[k]), 2);
      push_done(order[k], 5'(8 + order[k]));
    end
    rd_cnt = 0;
    first_rd = -1;
    g0 = grant_cnt;
    req_valid = 4'b1111;
    t = 0;
    while (grant_cnt - g0 < 5 && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    req_valid = '0;
    chk("t2_grants", 32'(grant_cnt - g0), 32'd5);
    drain("t2_drain");
    chk("t2_rdcnt", 32'(rd_cnt), 32'd10);
    chk("t2_span", 32'(last_rd - first_rd + 1), 32'd14);

    // req1 burst of 5 with a wb stall then a queue stall.
    set_req(1, 5'd7, 8'd5);
    push_beats(1, 5'd7, 5);
    push_done(1, 5'd7);
    req_valid = 4'b0010;
    @(negedge clk);
    chk("t3_ready", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    wb_pat = 7'b0000100;
    q_pat  = 7'b1101111;
    en_pat = 7'b1101011;
    for (int i = 0; i < 7; i++) begin
      wb_busy = wb_pat[i];
      q_ready = {2'b11, q_pat[i], 1'b1};
      @(negedge clk);
      chk("t3_rden", 32'(rd_en), 32'(en_pat[i]));
      step();
    end
    wb_busy = 1'b0;
    q_ready = '1;
    @(negedge clk);
    chk("t3_done", 32'(done), 32'd1);
`ifdef VRF_ARB_PERF_EN
    chk("perf_wb", perf_wb, 32'd1);
    chk("perf_q", perf_q, 32'd1);
`endif
    drain("t3_drain");

    // Empty burst on req2, then the pointer must sit at 3.
    set_req(2, 5'd9, 8'd0);
    push_done(2, 5'd9);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t4_ready", 32'(req_ready), 32'h4);
    step();
    set_req(0, 5'd1, 8'd1);
    set_req(1, 5'd2, 8'd1);
    set_req(3, 5'd4, 8'd1);
    push_beats(3, 5'd4, 1);
    push_done(3, 5'd4);
    req_valid = 4'b1011;
    @(negedge clk);
    chk("t4_done", 32'(done), 32'd1);
    chk("t4_no_rd", 32'(rd_en), 32'd0);
    chk("t4_ptr_grant", 32'(req_ready), 32'h8);
    step();
    req_valid = '0;
    @(negedge clk);
    chk("t4_rd_after", 32'(rd_en), 32'd1);
    drain("t4_drain");

    // Reset at beat 3 of an 8-beat burst.
    set_req(2, 5'd4, 8'd8);
    push_beats(2, 5'd4, 3);
    req_valid = 4'b0100;
    @(negedge clk);
    chk("t5_ready", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_rden", 32'(rd_en), 32'd1);
    end
    step();
    chk("t5_beat3_live", 32'({rd_en, rd_beat}), 32'h103);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5_rst");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_req(1, 5'd6, 8'd2);
    set_req(3, 5'd5, 8'd2);
    push_beats(1, 5'd6, 2);
    push_done(1, 5'd6);
    req_valid = 4'b1010;
    @(negedge clk);
    chk("t5_fresh_grant", 32'(req_ready), 32'h2);
    step();
    req_valid = '0;
    drain("t5_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
